// File: rtl/mobo_router.sv
// ----------------------------------------------------------------------------
// mobo_router
//
// Routes CPU bus requests to one of NUM_DEV memory-mapped device channels.
// The CPU address is split into a device index (upper bits) and a local
// offset (lower DEV_ADDR_BITS bits). A four-phase ctrl/stat handshake is run
// on the selected channel: ctrl asserted, device answers stat=1, ctrl
// withdrawn, device drops stat to 0, transaction complete.
//
// Optional feature macro: MOBO_ROUTER_TIMEOUT_EN
//   When defined, a wait counter aborts a transaction whose device does not
//   complete the handshake within TIMEOUT_CYCLES cycles and reports an error.
//
// Parameters:
//   WORD_WIDTH      data / address / ctrl / stat width (W)
//   NUM_DEV         number of device channels (>= 1)
//   DEV_ADDR_BITS   log2 of the words per device window
//   TIMEOUT_CYCLES  device wait limit (timeout build only)
//
// Ports:
//   clk        in   1           clock
//   rst        in   1           asynchronous active-high reset
//   cpu_ctrl   in   W           0 = none, bit0 = READ, bit1 = WRITE
//   cpu_stat   out  W           0 = IDLE, 1 = DONE, 2 = ERR
//   cpu_addr   in   W           global word address
//   cpu_wdata  in   W           write data
//   cpu_rdata  out  W           read data, valid while cpu_stat != 0
//   dev_ctrl   out  NUM_DEV*W   per-channel ctrl, channel i at [i*W +: W]
//   dev_stat   in   NUM_DEV*W   per-channel stat, 1 = DONE, 0 = idle
//   addr       out  W           local offset, zero-extended
//   data_out   out  W           shared write bus
//   data_in    in   W           shared read bus
//   err_dev    out  8           last errored channel, 8'hFF = decode error
// ----------------------------------------------------------------------------

`ifndef WORD_WIDTH
`define WORD_WIDTH 16
`endif

module mobo_router #(
    parameter int WORD_WIDTH     = `WORD_WIDTH,
    parameter int NUM_DEV        = 4,
    parameter int DEV_ADDR_BITS  = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [WORD_WIDTH-1:0]         cpu_ctrl,
    output logic [WORD_WIDTH-1:0]         cpu_stat,
    input  logic [WORD_WIDTH-1:0]         cpu_addr,
    input  logic [WORD_WIDTH-1:0]         cpu_wdata,
    output logic [WORD_WIDTH-1:0]         cpu_rdata,
    output logic [NUM_DEV*WORD_WIDTH-1:0] dev_ctrl,
    input  logic [NUM_DEV*WORD_WIDTH-1:0] dev_stat,
    output logic [WORD_WIDTH-1:0]         addr,
    output logic [WORD_WIDTH-1:0]         data_out,
    input  logic [WORD_WIDTH-1:0]         data_in,
    output logic [7:0]                    err_dev
);

    localparam int W     = WORD_WIDTH;
    localparam int IDX_W = (NUM_DEV > 1) ? $clog2(NUM_DEV) : 1;

    // Mask selecting the local offset bits of the CPU address.
    localparam logic [W-1:0] OFF_MASK =
        (DEV_ADDR_BITS >= W) ? {W{1'b1}} : ~({W{1'b1}} << DEV_ADDR_BITS);

    localparam logic [W-1:0] OP_READ   = W'(1);
    localparam logic [W-1:0] OP_WRITE  = W'(2);
    localparam logic [W-1:0] STAT_IDLE = W'(0);
    localparam logic [W-1:0] STAT_DONE = W'(1);
    localparam logic [W-1:0] STAT_ERR  = W'(2);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_WAIT    = 3'd1;
    localparam logic [2:0] S_RELEASE = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_ERR     = 3'd4;

    logic [2:0]       state_reg;
    logic [IDX_W-1:0] sel_reg;
    logic [W-1:0]     op_reg;
    logic [W-1:0]     addr_reg;
    logic [W-1:0]     data_out_reg;
    logic [W-1:0]     rdata_reg;
    logic [W-1:0]     stat_reg;
    logic [7:0]       err_dev_reg;

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic [W-1:0]     idx_full;
    logic [IDX_W-1:0] idx_sel;
    logic             dec_err;
    logic             req;
    logic [W-1:0]     op_next;
    logic             accept;
    logic             busy;
    logic [W-1:0]     sel_stat;
    logic             wait_done;
    logic             release_done;
    logic             timeout_hit;
    logic             ch_clear;

    assign idx_full = cpu_addr >> DEV_ADDR_BITS;
    assign idx_sel  = idx_full[IDX_W-1:0];
    assign dec_err  = (idx_full >= W'(NUM_DEV));

    // Only the READ/WRITE bits start a transaction; READ wins when both set.
    assign req     = |cpu_ctrl[1:0];
    assign op_next = cpu_ctrl[0] ? OP_READ : OP_WRITE;

    assign accept = (state_reg == S_IDLE) && req && !dec_err;
    assign busy   = (state_reg == S_WAIT) || (state_reg == S_RELEASE);

    // Only the selected channel's status is observed; others are ignored.
    assign sel_stat     = dev_stat[sel_reg*W +: W];
    assign wait_done    = (state_reg == S_WAIT) && (sel_stat == STAT_DONE);
    assign release_done = (state_reg == S_RELEASE) && (sel_stat == W'(0));

    // ctrl on the active channel is withdrawn on device ack or on abort.
    assign ch_clear = (state_reg == S_WAIT) && (wait_done || timeout_hit);

    // ------------------------------------------------------------------
    // Optional device wait timeout
    // ------------------------------------------------------------------
`ifdef MOBO_ROUTER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    logic [CNT_W-1:0] wait_cnt_reg;

    assign timeout_hit = busy && (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wait_cnt_reg <= '0;
        end else if (accept) begin
            wait_cnt_reg <= '0;
        end else if (busy && !timeout_hit) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    // ------------------------------------------------------------------
    // Per-channel ctrl registers: at most one channel is ever nonzero
    // because only the accepted index is loaded and it is cleared before
    // the FSM can return to IDLE.
    // ------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_DEV; gi++) begin : g_ch
            logic [W-1:0] ctrl_reg;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ctrl_reg <= '0;
                end else if (accept && (idx_sel == IDX_W'(gi))) begin
                    ctrl_reg <= op_next;
                end else if (ch_clear && (sel_reg == IDX_W'(gi))) begin
                    ctrl_reg <= '0;
                end
            end

            assign dev_ctrl[gi*W +: W] = ctrl_reg;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Transaction FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            sel_reg      <= '0;
            op_reg       <= '0;
            addr_reg     <= '0;
            data_out_reg <= '0;
            rdata_reg    <= '0;
            stat_reg     <= STAT_IDLE;
            err_dev_reg  <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (req) begin
                        if (dec_err) begin
                            state_reg   <= S_ERR;
                            stat_reg    <= STAT_ERR;
                            err_dev_reg <= 8'hFF;
                            rdata_reg   <= '0;
                        end else begin
                            // Latch everything so later CPU bus changes
                            // cannot disturb the transaction in flight.
                            state_reg    <= S_WAIT;
                            sel_reg      <= idx_sel;
                            op_reg       <= op_next;
                            addr_reg     <= cpu_addr & OFF_MASK;
                            data_out_reg <= cpu_wdata;
                        end
                    end
                end

                S_WAIT: begin
                    if (wait_done) begin
                        if (op_reg == OP_READ) begin
                            rdata_reg <= data_in;
                        end
                        state_reg <= S_RELEASE;
                    end else if (timeout_hit) begin
                        state_reg   <= S_ERR;
                        stat_reg    <= STAT_ERR;
                        err_dev_reg <= 8'(sel_reg);
                        rdata_reg   <= '0;
                    end
                end

                S_RELEASE: begin
                    if (release_done) begin
                        state_reg <= S_DONE;
                        stat_reg  <= STAT_DONE;
                    end else if (timeout_hit) begin
                        state_reg   <= S_ERR;
                        stat_reg    <= STAT_ERR;
                        err_dev_reg <= 8'(sel_reg);
                        rdata_reg   <= '0;
                    end
                end

                S_DONE, S_ERR: begin
                    // Forces the CPU to drop its request before the next one.
                    if (cpu_ctrl == '0) begin
                        state_reg <= S_IDLE;
                        stat_reg  <= STAT_IDLE;
                    end
                end

                default: begin
                    state_reg <= S_IDLE;
                    stat_reg  <= STAT_IDLE;
                end
            endcase
        end
    end

    assign cpu_stat  = stat_reg;
    assign cpu_rdata = rdata_reg;
    assign addr      = addr_reg;
    assign data_out  = data_out_reg;
    assign err_dev   = err_dev_reg;

endmodule

// File: tb/tb_mobo_router.sv
// ----------------------------------------------------------------------------
// tb_mobo_router
//
// Self-checking bench for mobo_router (W=16, NUM_DEV=4, DEV_ADDR_BITS=12,
// TIMEOUT_CYCLES=10). The bench acts as CPU and as the device side. Expected
// completions are pushed to a scoreboard queue when a request is driven and
// popped when the router reports DONE or ERR. The timeout scenario runs only
// when MOBO_ROUTER_TIMEOUT_EN is defined.
// ----------------------------------------------------------------------------

module tb_mobo_router;

    localparam int W  = 16;
    localparam int ND = 4;

    logic            clk;
    logic            rst;
    logic [W-1:0]    cpu_ctrl;
    logic [W-1:0]    cpu_stat;
    logic [W-1:0]    cpu_addr;
    logic [W-1:0]    cpu_wdata;
    logic [W-1:0]    cpu_rdata;
    logic [ND*W-1:0] dev_ctrl;
    logic [ND*W-1:0] dev_stat;
    logic [W-1:0]    addr;
    logic [W-1:0]    data_out;
    logic [W-1:0]    data_in;
    logic [7:0]      err_dev;

    mobo_router #(
        .WORD_WIDTH    (W),
        .NUM_DEV       (ND),
        .DEV_ADDR_BITS (12),
        .TIMEOUT_CYCLES(10)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cpu_ctrl (cpu_ctrl),
        .cpu_stat (cpu_stat),
        .cpu_addr (cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_rdata(cpu_rdata),
        .dev_ctrl (dev_ctrl),
        .dev_stat (dev_stat),
        .addr     (addr),
        .data_out (data_out),
        .data_in  (data_in),
        .err_dev  (err_dev)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [15:0] stat;
        logic [15:0] rdata;
        logic [7:0]  err;
        logic        chk_rdata;
    } exp_t;

    exp_t       sb_q[$];
    int         n_checks = 0;
    int         n_errors = 0;
    logic [7:0] exp_err  = 8'h00;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Wait (bounded) for a completion and compare it with the scoreboard head.
    task automatic wait_response(input int max_cyc);
        int   n;
        exp_t e;
        n = 0;
        while (cpu_stat == 16'd0 && n < max_cyc) begin
            @(posedge clk); #1;
            n++;
        end
        if (cpu_stat == 16'd0) begin
            check("resp_timeout", 64'd0, 64'd1);
        end else if (sb_q.size() == 0) begin
            check("sb_empty", 64'd0, 64'd1);
        end else begin
            e = sb_q.pop_front();
            check("resp_stat", cpu_stat, e.stat);
            check("resp_err_dev", err_dev, e.err);
            if (e.chk_rdata) check("resp_rdata", cpu_rdata, e.rdata);
        end
    endtask

    // One full CPU transaction, with the bench answering as the device.
    task automatic run_txn(input logic [15:0] ctrl, input logic [15:0] a,
                           input logic [15:0] wd, input logic [15:0] rd,
                           input int lat, input bit noise);
        int          idx;
        int          other;
        bit          is_read;
        bit          dec;
        logic [15:0] op;
        logic [63:0] exp_ctrl;
        exp_t        e;

        idx      = int'(a >> 12);
        is_read  = ctrl[0];
        op       = is_read ? 16'd1 : 16'd2;
        dec      = (idx >= ND);
        exp_ctrl = '0;
        if (!dec) exp_ctrl[idx*W +: W] = op;
        if (dec) exp_err = 8'hFF;

        e.stat      = dec ? 16'd2 : 16'd1;
        e.rdata     = dec ? 16'd0 : rd;
        e.err       = exp_err;
        e.chk_rdata = dec || is_read;
        sb_q.push_back(e);

        $display("txn ctrl=%h addr=%h wdata=%h rdata=%h lat=%0d noise=%0d",
                 ctrl, a, wd, rd, lat, noise);

        @(negedge clk);
        cpu_ctrl  = ctrl;
        cpu_addr  = a;
        cpu_wdata = wd;
        @(posedge clk); #1;

        if (dec) begin
            check("dec_ctrl", dev_ctrl, 64'd0);
            check("dec_stat", cpu_stat, 16'd2);
        end else begin
            check("req_ctrl", dev_ctrl, exp_ctrl);
            check("req_addr", addr, a & 16'h0FFF);
            check("req_data_out", data_out, wd);
            check("wait_stat", cpu_stat, 16'd0);

            @(negedge clk);
            cpu_addr  = a ^ 16'h5A5A;
            cpu_wdata = ~wd;
            if (noise) begin
                other = (idx + 1) % ND;
                dev_stat[other*W +: W] = 16'd1;
            end
            for (int i = 0; i < lat; i++) begin
                @(posedge clk); #1;
                check("hold_ctrl", dev_ctrl, exp_ctrl);
                check("hold_addr", addr, a & 16'h0FFF);
                check("hold_stat", cpu_stat, 16'd0);
                @(negedge clk);
            end

            dev_stat[idx*W +: W] = 16'd1;
            data_in = rd;
            @(posedge clk); #1;
            check("ack_ctrl", dev_ctrl, 64'd0);
            check("ack_stat", cpu_stat, 16'd0);
            if (!is_read) begin
                @(posedge clk); #1;
                check("release_hold_stat", cpu_stat, 16'd0);
            end

            @(negedge clk);
            dev_stat = '0;
            data_in  = 16'hDEAD;
            @(posedge clk); #1;
            check("done_latency", cpu_stat, 16'd1);
        end

        wait_response(4);
        if (!dec) begin
            check("post_addr", addr, a & 16'h0FFF);
            check("post_data_out", data_out, wd);
        end

        @(negedge clk);
        cpu_ctrl = '0;
        @(posedge clk); #1;
        check("idle_stat", cpu_stat, 16'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish, expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        cpu_ctrl  = '0;
        cpu_addr  = '0;
        cpu_wdata = '0;
        dev_stat  = '0;
        data_in   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_stat", cpu_stat, 16'd0);
        check("rst_rdata", cpu_rdata, 16'd0);
        check("rst_dev_ctrl", dev_ctrl, 64'd0);
        check("rst_addr", addr, 16'd0);
        check("rst_data_out", data_out, 16'd0);
        check("rst_err_dev", err_dev, 8'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Read, channel 1, device answers after two cycles
        run_txn(16'd1, 16'h1005, 16'h0000, 16'hBEEF, 2, 1'b0);
        // Write, channel 3
        run_txn(16'd2, 16'h3ABC, 16'h1234, 16'h0000, 1, 1'b0);
        // Decode error
        run_txn(16'd1, 16'h4000, 16'h0000, 16'h0000, 0, 1'b0);
        // READ|WRITE resolves to READ, noise on a neighbour channel
        run_txn(16'd3, 16'h0123, 16'h7777, 16'hCAFE, 3, 1'b1);
        // Same-cycle device, channel 2; err_dev still holds the decode error
        run_txn(16'd1, 16'h2FFF, 16'h0000, 16'h0F0F, 0, 1'b0);
        // Decode error at the very top of the address space
        run_txn(16'd2, 16'hFFFF, 16'h1111, 16'h0000, 0, 1'b0);

`ifdef MOBO_ROUTER_TIMEOUT_EN
        begin
            exp_t e;
            int   n;
            exp_err     = 8'd2;
            e.stat      = 16'd2;
            e.rdata     = 16'd0;
            e.err       = 8'd2;
            e.chk_rdata = 1'b1;
            sb_q.push_back(e);
            $display("txn ctrl=0001 addr=2010 timeout, device 2 silent");
            @(negedge clk);
            cpu_ctrl = 16'd1;
            cpu_addr = 16'h2010;
            @(posedge clk); #1;
            check("to_req_ctrl", dev_ctrl, 64'h0000_0001_0000_0000);
            n = 1;
            while (cpu_stat == 16'd0 && n < 12) begin
                @(posedge clk); #1;
                n++;
            end
            check("to_dev_ctrl", dev_ctrl, 64'd0);
            wait_response(0);
            @(negedge clk);
            cpu_ctrl = '0;
            @(posedge clk); #1;
            check("to_idle_stat", cpu_stat, 16'd0);
        end
`endif

        // Reset while waiting on channel 2
        $display("txn ctrl=0001 addr=2003 reset during WAIT");
        @(negedge clk);
        cpu_ctrl = 16'd1;
        cpu_addr = 16'h2003;
        @(posedge clk); #1;
        check("rw_req_ctrl", dev_ctrl, 64'h0000_0001_0000_0000);
        #2;
        rst = 1'b1;
        #1;
        check("rw_dev_ctrl", dev_ctrl, 64'd0);
        check("rw_stat", cpu_stat, 16'd0);
        check("rw_addr", addr, 16'd0);
        check("rw_err_dev", err_dev, 8'd0);
        exp_err = 8'h00;
        @(negedge clk);
        cpu_ctrl = '0;
        rst      = 1'b0;
        @(negedge clk);

        // Normal transaction after reset release
        run_txn(16'd1, 16'h2003, 16'h0000, 16'h4321, 1, 1'b0);

        check("sb_drained", sb_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mobo_router.md
# mobo_router

Parametrised successor to the motherboard bus controller. Sits between the CPU's `mobo_ctrl`/`mobo_stat` port and `NUM_DEV` memory-mapped devices (RAM, VGA, future peripherals). It decodes the CPU address into a device index plus local offset, and runs a four-phase ctrl/stat handshake on the selected channel. Read data is returned to the CPU, and bad addresses or unresponsive devices are reported as errors.

## Interface
- `WORD_WIDTH`, default `` `WORD_WIDTH `` (16): data, address, ctrl and stat width.
- `NUM_DEV`, default 4: device channels, at least 1.
- `DEV_ADDR_BITS`, default 12: log2 of the words per device window.
- `TIMEOUT_CYCLES`, default 255: device wait limit. Used only with `MOBO_ROUTER_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cpu_ctrl`  in  W  CPU request. 0 = none; bit0 = READ (1); bit1 = WRITE (2).
- `cpu_stat`  out  W  0 = IDLE, 1 = DONE, 2 = ERR.
- `cpu_addr`  in  W  global word address.
- `cpu_wdata`  in  W  write data.
- `cpu_rdata`  out  W  read data, valid while `cpu_stat` != 0.
- `dev_ctrl`  out  NUM_DEV*W  per-channel ctrl. Channel i occupies `[i*W +: W]`.
- `dev_stat`  in  NUM_DEV*W  per-channel stat. 1 = DONE, 0 = idle.
- `addr`  out  W  local offset (`cpu_addr[DEV_ADDR_BITS-1:0]`, zero-extended).
- `data_out`  out  W  shared write bus.
- `data_in`  in  W  shared read bus.
- `err_dev`  out  8  index of the last errored channel. 8'hFF = address decode error.

## Operation
**Address decode**
- `idx = cpu_addr >> DEV_ADDR_BITS`.
- `idx >= NUM_DEV` is a decode error.

**Operation select**
- When both READ and WRITE bits are set, READ wins.

**FSM states:** IDLE, WAIT, RELEASE, DONE, ERR.
- **IDLE**
  - `cpu_ctrl == 0`: stay.
  - Decode error: go to ERR, with `err_dev = FF` and `cpu_rdata = 0`.
  - Otherwise: latch `idx`, op, `addr` and `data_out`; drive `dev_ctrl[idx] = op`; go to WAIT.
- **WAIT**
  - Hold `dev_ctrl[idx]`.
  - On `dev_stat[idx] == 1`:
    - capture `data_in` into `cpu_rdata` (reads only);
    - clear `dev_ctrl[idx]` to 0;
    - go to RELEASE.
- **RELEASE**
  - On `dev_stat[idx] == 0`: go to DONE.
- **DONE** (`cpu_stat = 1`) and **ERR** (`cpu_stat = 2`)
  - Hold until `cpu_ctrl == 0`, then go to IDLE and set `cpu_stat = 0`.

**Rules**
- Only one channel's `dev_ctrl` is nonzero at any time. All other channels stay 0.
- `addr`, `data_out` and `cpu_rdata` are held stable from the start of WAIT until the FSM returns to IDLE.
- Changes to `cpu_addr`/`cpu_wdata` after acceptance are ignored.
- A new request is accepted only in IDLE. This requires `cpu_ctrl` to have been 0 for at least one cycle.
- `dev_stat` on non-selected channels is ignored.

## Timing
- All outputs are registered.
- Reset values: `cpu_stat = 0`, `cpu_rdata = 0`, `dev_ctrl = 0`, `addr = 0`, `data_out = 0`, `err_dev = 0`, FSM in IDLE.
- Request sampled in IDLE at edge n: `dev_ctrl` is asserted after edge n+1.
- `dev_stat = 1` sampled at edge m: `dev_ctrl = 0` and `cpu_rdata` are valid after edge m+1.
- `dev_stat = 0` sampled at edge r: `cpu_stat = 1` after edge r+1.
- `cpu_ctrl = 0` sampled at edge c: `cpu_stat = 0` after edge c+1.
- Minimum transaction, with a device that responds in the same cycle: 3 cycles from request to DONE.
- Decode error: `cpu_stat = 2` one cycle after the request is sampled.
- Reset mid-operation: all outputs clear immediately (asynchronous), and the FSM returns to IDLE. The device must tolerate ctrl being withdrawn.

## Configuration
`MOBO_ROUTER_TIMEOUT_EN`

**Defined**
- A counter runs in WAIT and RELEASE. It is cleared on entry to WAIT.
- When the counter reaches `TIMEOUT_CYCLES`:
  - clear `dev_ctrl[idx]`;
  - set `err_dev = idx` and `cpu_rdata = 0`;
  - go to ERR.

**Undefined**
- No counter is built. WAIT and RELEASE wait indefinitely.
- `err_dev` changes only on decode errors.

## Test plan
- **Read, channel 1:** W=16, DEV_ADDR_BITS=12. `cpu_addr = 16'h1005`, `cpu_ctrl = 1`; device 1 returns `data_in = 16'hBEEF` with stat=1 two cycles later → `addr = 16'h005`, `dev_ctrl[1] = 1`, all other channels 0, `cpu_rdata = 16'hBEEF`, `cpu_stat = 1`; after `cpu_ctrl = 0`, `cpu_stat = 0`.
- **Write, channel 3:** `cpu_addr = 16'h3ABC`, `cpu_wdata = 16'h1234`, `cpu_ctrl = 2` → `dev_ctrl[3] = 2`, `data_out = 16'h1234`, `addr = 16'hABC`; DONE only after device 3 stat returns to 0.
- **Decode error:** `cpu_addr = 16'h4000` with NUM_DEV=4, `cpu_ctrl = 1` → no `dev_ctrl` asserted, `cpu_stat = 2` the next cycle, `err_dev = 8'hFF`.
- **READ|WRITE and mid-transaction address change:** `cpu_ctrl = 3` → READ issued (`dev_ctrl = 1`); changing `cpu_addr` during WAIT leaves `addr` unchanged.
- **Timeout (macro defined, TIMEOUT_CYCLES=10):** device 2 never responds → `dev_ctrl[2]` cleared, `cpu_stat = 2`, `err_dev = 2` within 12 cycles of the request.
- **Reset in WAIT:** assert `rst` → `dev_ctrl = 0` and `cpu_stat = 0` without waiting for a clock edge; the next request after `rst` is released completes normally.
